// File: rtl/prio_enc_seg_display_pkg.sv
// Seven-segment glyph constants and digit lookup.
// Segments are {g,f,e,d,c,b,a}, active-low.
package seg7_pkg;

    localparam logic [6:0] SEG_DASH  = 7'h3F;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

    function automatic logic [6:0] dig2seg(input logic [3:0] d);
        logic [6:0] r;
        r = SEG_BLANK;
        for (int i = 0; i < 10; i++) begin
            if (d == 4'(i)) r = SEG_DIGIT[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/prio_enc_seg_display_if.sv
// Request/result/display bundle of the priority encoder display.
// slave = the block, master = whoever drives x/sample/mode.
interface prio_enc_seg_display_if #(
    parameter int IN_W = 8
);
    localparam int IDX_W = $clog2(IN_W);

    logic [IN_W-1:0]  x;
    logic             sample;
    logic             mode;
    logic [IDX_W-1:0] idx;
    logic             valid;
    logic             changed;
    logic [3:0]       seg_an;
    logic [6:0]       seg;
    logic [1:0]       ptr;
    logic             slot_wrap;

    modport master (
        output x, sample, mode,
        input  idx, valid, changed, seg_an, seg, ptr, slot_wrap
    );

    modport slave (
        input  x, sample, mode,
        output idx, valid, changed, seg_an, seg, ptr, slot_wrap
    );

endinterface

// File: rtl/prio_enc_seg_display_scan.sv
// Digit scanner: slot divider, 2-bit digit pointer, registered anodes.
// Anodes lag ptr by one clk so they line up with the registered segments.
module seg7_scan #(
    parameter int SCAN_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [1:0] ptr_o,
    output logic [3:0] seg_an_o,
    output logic       wrap_o
);
    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [3:0]       seg_an_q, seg_an_d;

    always_comb begin
        wrap_o   = (div_q == DIV_W'(SCAN_DIV - 1));
        div_d    = wrap_o ? '0 : div_q + DIV_W'(1);
        ptr_d    = wrap_o ? ptr_q + 2'd1 : ptr_q;
        seg_an_d = ~(4'b0001 << ptr_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q    <= '0;
            ptr_q    <= 2'd0;
            seg_an_q <= 4'b1110;
        end else begin
            div_q    <= div_d;
            ptr_q    <= ptr_d;
            seg_an_q <= seg_an_d;
        end
    end

    assign ptr_o    = ptr_q;
    assign seg_an_o = seg_an_q;

endmodule

// File: rtl/prio_enc_seg_display.sv
// Sampled priority encoder feeding a 4-digit multiplexed 7-seg bank.
// Index shown in decimal (mode=0) or as binary bits (mode=1).
module prio_enc_seg_display
    import seg7_pkg::*;
#(
    parameter int IN_W     = 8,
    parameter int SCAN_DIV = 50000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    prio_enc_seg_display_if.slave bus
);
    localparam int IDX_W = $clog2(IN_W);

    logic [IN_W-1:0]  x_q, x_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             valid_q, valid_d;
    logic             changed_q, changed_d;
    logic [6:0]       seg_q, seg_d;

    logic [1:0]       ptr;
    logic [3:0]       seg_an;
    logic             slot_wrap;
    logic [3:0]       idx_ext;

    seg7_scan #(
        .SCAN_DIV (SCAN_DIV)
    ) u_scan (
        .clk      (clk),
        .rst_n    (rst_n),
        .ptr_o    (ptr),
        .seg_an_o (seg_an),
        .wrap_o   (slot_wrap)
    );

    always_comb begin
        x_d = bus.sample ? bus.x : x_q;
    end

    // Low-to-high scan: the last set bit seen is the highest one.
    always_comb begin
        idx_d   = '0;
        valid_d = 1'b0;
        for (int i = 0; i < IN_W; i++) begin
            if (x_q[i]) begin
                idx_d   = IDX_W'(i);
                valid_d = 1'b1;
            end
        end
        changed_d = ({valid_d, idx_d} != {valid_q, idx_q});
    end

    always_comb begin
        idx_ext = 4'(idx_q);
        seg_d   = SEG_BLANK;
        unique case (1'b1)
            !valid_q: begin
                seg_d = SEG_DASH;
            end
            valid_q && !bus.mode: begin
                if (ptr == 2'd0)
                    seg_d = dig2seg(idx_ext % 4'd10);
                else if (ptr == 2'd1 && idx_ext >= 4'd10)
                    seg_d = SEG_DIGIT[1];
            end
            valid_q && bus.mode: begin
                if (int'(ptr) < IDX_W)
                    seg_d = idx_ext[ptr] ? SEG_DIGIT[1] : SEG_DIGIT[0];
            end
            default: begin
                seg_d = SEG_BLANK;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q       <= '0;
            idx_q     <= '0;
            valid_q   <= 1'b0;
            changed_q <= 1'b0;
            seg_q     <= SEG_DASH;
        end else begin
            x_q       <= x_d;
            idx_q     <= idx_d;
            valid_q   <= valid_d;
            changed_q <= changed_d;
            seg_q     <= seg_d;
        end
    end

    assign bus.idx       = idx_q;
    assign bus.valid     = valid_q;
    assign bus.changed   = changed_q;
    assign bus.seg_an    = seg_an;
    assign bus.seg       = seg_q;
    assign bus.ptr       = ptr;
    assign bus.slot_wrap = slot_wrap;

endmodule

// File: tb/tb_prio_enc_seg_display.sv
// Directed bench for prio_enc_seg_display (IN_W=8 and IN_W=16, SCAN_DIV=4).
// Scan position is modelled from a cycle count since reset release.
module tb_prio_enc_seg_display;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    prio_enc_seg_display_if #(.IN_W(8))  b8 ();
    prio_enc_seg_display_if #(.IN_W(16)) b16 ();

    prio_enc_seg_display #(
        .IN_W     (8),
        .SCAN_DIV (4)
    ) u8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b8)
    );

    prio_enc_seg_display #(
        .IN_W     (16),
        .SCAN_DIV (4)
    ) u16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b16)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    logic [6:0] bin_exp [4] = '{7'h40, 7'h79, 7'h79, 7'h7F};
    logic [6:0] six_exp [4] = '{7'h02, 7'h7F, 7'h7F, 7'h7F};
    logic [6:0] dec_exp [4] = '{7'h79, 7'h79, 7'h7F, 7'h7F};

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic int slot(input int c);
        return ((c - 1) / 4) % 4;
    endfunction

    function automatic logic [3:0] an_exp(input int s);
        return ~(4'b0001 << s);
    endfunction

    task automatic smp8(input logic [7:0] v);
        b8.x      = v;
        b8.sample = 1'b1;
        tick();
        b8.sample = 1'b0;
    endtask

    initial begin
        bit found;
        int s;

        b8.x = '0;  b8.sample = 1'b0;  b8.mode = 1'b0;
        b16.x = '0; b16.sample = 1'b0; b16.mode = 1'b0;

        rst_n = 1'b0;
        tick();
        tick();
        chk("rst_an",      b8.seg_an,  4'b1110);
        chk("rst_seg",     b8.seg,     7'h3F);
        chk("rst_idx",     b8.idx,     0);
        chk("rst_valid",   b8.valid,   0);
        chk("rst_changed", b8.changed, 0);
        chk("rst_ptr",     b8.ptr,     0);

        rst_n = 1'b1;
        cyc   = 0;
        for (int k = 1; k <= 16; k++) begin
            tick();
            chk("scan_ptr",  b8.ptr, (cyc / 4) % 4);
            chk("scan_an",   b8.seg_an, an_exp(slot(cyc)));
            chk("scan_dash", b8.seg, 7'h3F);
            chk("scan_wrap", b8.slot_wrap, (cyc % 4) == 3);
        end

        smp8(8'h2C);
        chk("pri_lat_valid", b8.valid, 0);
        tick();
        chk("pri_idx5",    b8.idx,     5);
        chk("pri_valid5",  b8.valid,   1);
        chk("pri_chg5",    b8.changed, 1);
        tick();
        chk("pri_chg5_off", b8.changed, 0);

        smp8(8'h81);
        tick();
        chk("pri_idx7", b8.idx,     7);
        chk("pri_chg7", b8.changed, 1);

        smp8(8'h00);
        tick();
        chk("pri_zero_valid", b8.valid,   0);
        chk("pri_zero_idx",   b8.idx,     0);
        chk("pri_zero_chg",   b8.changed, 1);

        b8.mode = 1'b1;
        smp8(8'h40);
        tick();
        chk("bin_idx6", b8.idx, 6);
        tick();
        for (int k = 0; k < 8; k++) begin
            tick();
            s = slot(cyc);
            chk("bin_an",  b8.seg_an, an_exp(s));
            chk("bin_seg", b8.seg,    bin_exp[s]);
        end

        b8.mode = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            s = slot(cyc);
            chk("mode_dec_seg", b8.seg, six_exp[s]);
        end

        b16.mode   = 1'b0;
        b16.x      = 16'h0800;
        b16.sample = 1'b1;
        tick();
        b16.sample = 1'b0;
        tick();
        chk("dec_idx11",   b16.idx,   11);
        chk("dec_valid11", b16.valid, 1);
        tick();
        for (int k = 0; k < 8; k++) begin
            tick();
            s = slot(cyc);
            chk("dec_an",  b16.seg_an, an_exp(s));
            chk("dec_seg", b16.seg,    dec_exp[s]);
        end

        smp8(8'h01);
        tick();
        tick();
        b8.x      = 8'h01;
        b8.sample = 1'b1;
        tick();
        b8.x = 8'h02;
        tick();
        chk("b2b_idx0", b8.idx,     0);
        chk("b2b_chg0", b8.changed, 0);
        b8.x = 8'h04;
        tick();
        chk("b2b_idx1", b8.idx,     1);
        chk("b2b_chg1", b8.changed, 1);
        b8.sample = 1'b0;
        tick();
        chk("b2b_idx2", b8.idx,     2);
        chk("b2b_chg2", b8.changed, 1);
        tick();
        chk("b2b_chg_off", b8.changed, 0);

        smp8(8'h81);
        tick();
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (b8.ptr == 2'd2) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        chk("mid_ptr2_found", found,    1);
        chk("mid_valid_pre",  b8.valid, 1);

        rst_n = 1'b0;
        #1;
        chk("mid_ptr",     b8.ptr,     0);
        chk("mid_an",      b8.seg_an,  4'b1110);
        chk("mid_seg",     b8.seg,     7'h3F);
        chk("mid_idx",     b8.idx,     0);
        chk("mid_valid",   b8.valid,   0);
        chk("mid_changed", b8.changed, 0);
        chk("mid_idx16",   b16.idx,    0);
        tick();
        rst_n = 1'b1;
        cyc   = 0;
        tick();
        chk("rel_ptr0", b8.ptr,    0);
        chk("rel_an0",  b8.seg_an, 4'b1110);
        tick();
        tick();
        tick();
        chk("rel_ptr1",  b8.ptr,   1);
        chk("rel_valid", b8.valid, 0);
        chk("rel_seg",   b8.seg,   7'h3F);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
